// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared state encoding, operation classes and defaults for the load/store unit
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        OP_LOAD    = 2'd0,
        OP_STORE   = 2'd1,
        OP_BYPASS  = 2'd2,
        OP_ILLEGAL = 2'd3
    } lsu_op_e;

    localparam logic [31:0] LSU_FAULT_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic lsu_op_e lsu_classify(input logic mem_read, input logic mem_write);
        lsu_op_e op;
        case ({mem_read, mem_write})
            2'b10:   op = OP_LOAD;
            2'b01:   op = OP_STORE;
            2'b00:   op = OP_BYPASS;
            default: op = OP_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lsu_timeout_counter.sv
// rtl/lsu_timeout_counter.sv - ISSUE-cycle watchdog, instantiated by the top only under LSU_TIMEOUT_EN
module lsu_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    // Fires on the stalled cycle that brings the count to TIMEOUT_CYCLES, so the
    // request stays up for exactly TIMEOUT_CYCLES cycles.
    assign expired = inc && (count_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit; optional ISSUE timeout under LSU_TIMEOUT_EN
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 8,
    parameter logic [31:0] FAULT_DATA     = LSU_FAULT_DATA_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        exValid,
    input  logic        exMemRead,
    input  logic        exMemWrite,
    input  logic        exMemToReg,
    input  logic [31:0] exAddress,
    input  logic [31:0] exWriteData,
    input  logic [4:0]  exDestReg,
    output logic        lsuReady,
    output logic        cacheReq,
    output logic        memRead,
    output logic        memWrite,
    output logic        memToReg,
    output logic [31:0] address,
    output logic [31:0] writeData,
    input  logic        cacheAck,
    input  logic [31:0] readData,
    output logic        wbValid,
    output logic [31:0] wbData,
    output logic [4:0]  wbDestReg,
    output logic        wbRegWrite,
    output logic        wbFault
);

    lsu_state_e  state_q, state_d;
    lsu_op_e     op_q, op_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic        wb_fault_q, wb_fault_d;

    logic    in_idle, in_issue, in_resp;
    logic    timeout_expired;
    lsu_op_e ex_op;
    logic    ex_misaligned;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_issue = (state_q == ST_ISSUE);
    assign in_resp  = (state_q == ST_RESP);

    assign ex_op         = lsu_classify(exMemRead, exMemWrite);
    assign ex_misaligned = ((ex_op == OP_LOAD) || (ex_op == OP_STORE)) && (exAddress[1:0] != 2'b00);

`ifdef LSU_TIMEOUT_EN
    lsu_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!in_issue),
        .inc     (in_issue && !cacheAck),
        .expired (timeout_expired)
    );
`else
    logic [31:0] timeout_cycles_unused;
    assign timeout_cycles_unused = 32'(TIMEOUT_CYCLES);
    assign timeout_expired       = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        mem_to_reg_d   = mem_to_reg_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        dest_d         = dest_q;
        wb_data_d      = wb_data_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_fault_d     = wb_fault_q;

        case (state_q)
            ST_IDLE: begin
                if (exValid) begin
                    op_d         = ex_op;
                    mem_read_d   = exMemRead;
                    mem_write_d  = exMemWrite;
                    mem_to_reg_d = exMemToReg;
                    addr_d       = exAddress;
                    wdata_d      = exWriteData;
                    dest_d       = exDestReg;
                    // Anything that never reaches the cache resolves its result right here.
                    if ((ex_op == OP_ILLEGAL) || ex_misaligned) begin
                        wb_data_d      = FAULT_DATA;
                        wb_reg_write_d = 1'b0;
                        wb_fault_d     = 1'b1;
                        state_d        = ST_RESP;
                    end else if (ex_op == OP_BYPASS) begin
                        wb_data_d      = exAddress;
                        wb_reg_write_d = exMemToReg;
                        wb_fault_d     = 1'b0;
                        state_d        = ST_RESP;
                    end else begin
                        state_d        = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // A same-cycle ack beats the timeout.
                if (cacheAck) begin
                    wb_fault_d = 1'b0;
                    if (op_q == OP_LOAD) begin
                        wb_data_d      = readData;
                        wb_reg_write_d = mem_to_reg_q;
                    end else begin
                        wb_data_d      = wdata_q;
                        wb_reg_write_d = 1'b0;
                    end
                    state_d = ST_RESP;
                end else if (timeout_expired) begin
                    wb_data_d      = FAULT_DATA;
                    wb_reg_write_d = 1'b0;
                    wb_fault_d     = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_BYPASS;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            dest_q         <= '0;
            wb_data_q      <= '0;
            wb_reg_write_q <= 1'b0;
            wb_fault_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            dest_q         <= dest_d;
            wb_data_q      <= wb_data_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_fault_q     <= wb_fault_d;
        end
    end

    // Outputs are gated by state so the reset state alone forces them to zero.
    assign lsuReady   = in_idle;
    assign cacheReq   = in_issue;
    assign memRead    = in_issue && mem_read_q;
    assign memWrite   = in_issue && mem_write_q;
    assign memToReg   = in_issue && mem_to_reg_q;
    assign address    = in_issue ? addr_q  : 32'h0;
    assign writeData  = in_issue ? wdata_q : 32'h0;

    assign wbValid    = in_resp;
    assign wbData     = in_resp ? wb_data_q : 32'h0;
    assign wbDestReg  = in_resp ? dest_q    : 5'h0;
    assign wbRegWrite = in_resp && wb_reg_write_q;
    assign wbFault    = in_resp && wb_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        exValid, exMemRead, exMemWrite, exMemToReg;
    logic [31:0] exAddress, exWriteData;
    logic [4:0]  exDestReg;
    logic        lsuReady, cacheReq, memRead, memWrite, memToReg;
    logic [31:0] address, writeData;
    logic        cacheAck;
    logic [31:0] readData;
    logic        wbValid;
    logic [31:0] wbData;
    logic [4:0]  wbDestReg;
    logic        wbRegWrite, wbFault;

    int n_checks = 0;
    int n_fail   = 0;
    int n_req;

    always #5 clock = ~clock;

    load_store_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .exValid     (exValid),
        .exMemRead   (exMemRead),
        .exMemWrite  (exMemWrite),
        .exMemToReg  (exMemToReg),
        .exAddress   (exAddress),
        .exWriteData (exWriteData),
        .exDestReg   (exDestReg),
        .lsuReady    (lsuReady),
        .cacheReq    (cacheReq),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .memToReg    (memToReg),
        .address     (address),
        .writeData   (writeData),
        .cacheAck    (cacheAck),
        .readData    (readData),
        .wbValid     (wbValid),
        .wbData      (wbData),
        .wbDestReg   (wbDestReg),
        .wbRegWrite  (wbRegWrite),
        .wbFault     (wbFault)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic rd, input logic wr, input logic to_reg,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] dest);
        exValid     = 1'b1;
        exMemRead   = rd;
        exMemWrite  = wr;
        exMemToReg  = to_reg;
        exAddress   = addr;
        exWriteData = wdata;
        exDestReg   = dest;
        step();
        exValid     = 1'b0;
        exAddress   = 32'h5555_5555;
        exWriteData = 32'hAAAA_AAAA;
    endtask

    initial begin
        reset_n     = 1'b0;
        exValid     = 1'b0;
        exMemRead   = 1'b0;
        exMemWrite  = 1'b0;
        exMemToReg  = 1'b0;
        exAddress   = 32'h0;
        exWriteData = 32'h0;
        exDestReg   = 5'h0;
        cacheAck    = 1'b0;
        readData    = 32'h0;

        #12;
        check("rst_cacheReq", cacheReq, 0);
        check("rst_wbValid", wbValid, 0);
        check("rst_address", address, 0);
        check("rst_wbData", wbData, 0);
        check("rst_wbDestReg", wbDestReg, 0);
        #5 reset_n = 1'b1;
        step();
        check("post_rst_ready", lsuReady, 1);

        // bypass: result is the ALU value, one cycle after accept
        offer(1'b0, 1'b0, 1'b0, 32'h0000_00FF, 32'h0, 5'd3);
        check("byp_cacheReq", cacheReq, 0);
        check("byp_wbValid", wbValid, 1);
        check("byp_wbData", wbData, 32'h0000_00FF);
        check("byp_wbRegWrite", wbRegWrite, 0);
        check("byp_wbDest", wbDestReg, 3);
        check("byp_ready", lsuReady, 0);
        step();
        check("byp_wbValid_drop", wbValid, 0);
        check("byp_ready_back", lsuReady, 1);

        // load with ack after two ISSUE cycles
        offer(1'b1, 1'b0, 1'b1, 32'h0000_1008, 32'h0, 5'd5);
        check("ld_cacheReq1", cacheReq, 1);
        check("ld_memRead", memRead, 1);
        check("ld_memWrite", memWrite, 0);
        check("ld_memToReg", memToReg, 1);
        check("ld_address", address, 32'h0000_1008);
        step();
        check("ld_cacheReq2", cacheReq, 1);
        check("ld_address2", address, 32'h0000_1008);
        cacheAck = 1'b1;
        readData = 32'h0202_0202;
        step();
        cacheAck = 1'b0;
        readData = 32'h7777_7777;
        check("ld_wbValid", wbValid, 1);
        check("ld_wbData", wbData, 32'h0202_0202);
        check("ld_wbRegWrite", wbRegWrite, 1);
        check("ld_wbFault", wbFault, 0);
        check("ld_wbDest", wbDestReg, 5);
        check("ld_cacheReq_off", cacheReq, 0);
        step();
        check("ld_wbValid_drop", wbValid, 0);

        // store with immediate ack
        offer(1'b0, 1'b1, 1'b1, 32'h0000_1010, 32'hC0DE_BABE, 5'd7);
        check("st_memWrite", memWrite, 1);
        check("st_memRead", memRead, 0);
        check("st_address", address, 32'h0000_1010);
        check("st_writeData", writeData, 32'hC0DE_BABE);
        cacheAck = 1'b1;
        step();
        cacheAck = 1'b0;
        check("st_wbValid", wbValid, 1);
        check("st_wbData", wbData, 32'hC0DE_BABE);
        check("st_wbRegWrite", wbRegWrite, 0);
        check("st_writeData_off", writeData, 0);
        step();

        // misaligned load never reaches the cache
        offer(1'b1, 1'b0, 1'b1, 32'h0000_1002, 32'h0, 5'd9);
        check("mis_cacheReq", cacheReq, 0);
        check("mis_wbValid", wbValid, 1);
        check("mis_wbFault", wbFault, 1);
        check("mis_wbData", wbData, 32'hDEAD_BEEF);
        check("mis_wbRegWrite", wbRegWrite, 0);
        step();

        // illegal read+write
        offer(1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'h0, 5'd2);
        check("ill_cacheReq", cacheReq, 0);
        check("ill_wbFault", wbFault, 1);
        check("ill_wbData", wbData, 32'hDEAD_BEEF);
        step();
        check("ill_ready_back", lsuReady, 1);

`ifdef LSU_TIMEOUT_EN
        offer(1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'h0, 5'd4);
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            if (cacheReq !== 1'b1) break;
            n_req++;
            step();
        end
        check("to_req_cycles", n_req, 8);
        check("to_wbValid", wbValid, 1);
        check("to_wbFault", wbFault, 1);
        check("to_wbData", wbData, 32'hDEAD_BEEF);
        cacheAck = 1'b1;
        readData = 32'h1234_5678;
        step();
        cacheAck = 1'b0;
        check("to_late_ack_wbValid", wbValid, 0);
        check("to_late_ack_ready", lsuReady, 1);
        step();
        check("to_late_ack_idle", wbValid, 0);
`else
        offer(1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'h0, 5'd4);
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            if (cacheReq === 1'b1) n_req++;
            step();
        end
        check("wait_req_cycles", n_req, 20);
        cacheAck = 1'b1;
        readData = 32'h1234_5678;
        step();
        cacheAck = 1'b0;
        check("wait_wbData", wbData, 32'h1234_5678);
        check("wait_wbFault", wbFault, 0);
        step();
`endif

        // reset in the second ISSUE cycle abandons the request
        offer(1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 5'd6);
        step();
        check("rsti_cacheReq_pre", cacheReq, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rsti_cacheReq", cacheReq, 0);
        check("rsti_memRead", memRead, 0);
        check("rsti_address", address, 0);
        check("rsti_wbValid", wbValid, 0);
        reset_n  = 1'b1;
        cacheAck = 1'b1;
        readData = 32'h9999_9999;
        step();
        cacheAck = 1'b0;
        check("rsti_ready", lsuReady, 1);
        check("rsti_no_wb", wbValid, 0);
        check("rsti_no_req", cacheReq, 0);
        step();
        check("rsti_no_wb2", wbValid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8, meaning the number of ISSUE cycles without cacheAck before abort.
REQ-002 SHALL have parameter FAULT_DATA, default 32'hDEAD_BEEF, meaning the wbData value driven on any fault.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have inputs exValid (1), exMemRead (1), exMemWrite (1), exMemToReg (1), exAddress (32), exWriteData (32), exDestReg (5): operation offered by the execute stage.
REQ-006 SHALL have output lsuReady (1): high only in IDLE; the operation is accepted on exValid&&lsuReady.
REQ-007 SHALL have outputs cacheReq (1), memRead (1), memWrite (1), memToReg (1), address (32), writeData (32): request to the data cache.
REQ-008 SHALL have inputs cacheAck (1) and readData (32): cache completion and load data, valid only when cacheAck=1.
REQ-009 SHALL have outputs wbValid (1), wbData (32), wbDestReg (5), wbRegWrite (1), wbFault (1): result to the writeback stage.

Function
REQ-010 SHALL implement states IDLE, ISSUE, RESP.
REQ-011 On accept in IDLE, SHALL register all ex* inputs, then classify: load (read=1, write=0), store (read=0, write=1), bypass (both 0), illegal (both 1).
REQ-012 Load or store with exAddress[1:0]!=0 SHALL be a misalignment fault; no cacheReq is issued.
REQ-013 Aligned load/store SHALL go IDLE->ISSUE; bypass, illegal and misaligned SHALL go IDLE->RESP directly.
REQ-014 In ISSUE, cacheReq SHALL be 1 and memRead, memWrite, memToReg, address and writeData SHALL hold the registered values, stable until cacheAck is sampled high.
REQ-015 cacheAck sampled high in ISSUE SHALL capture readData (loads) and move to RESP; cacheAck outside ISSUE SHALL be ignored.
REQ-016 RESP SHALL last exactly one cycle with wbValid=1, then return to IDLE.
REQ-017 wbData SHALL be: load -> captured readData; store -> registered writeData; bypass -> registered exAddress (ALU result passthrough); any fault -> FAULT_DATA.
REQ-018 wbRegWrite SHALL be registered exMemToReg for loads and bypass, and 0 for stores and faults.
REQ-019 wbFault SHALL be 1 for illegal, misaligned or timed-out operations.
REQ-020 Minimum latency: accept at edge T, cacheReq high after T, ack sampled at T+1, wbValid high after T+1 until T+2; bypass has wbValid high after T until T+1.
REQ-021 All cache-side outputs SHALL be 0 outside ISSUE.

Reset
REQ-022 reset_n low SHALL immediately force IDLE and drive cacheReq, memRead, memWrite, memToReg, wbValid, wbRegWrite and wbFault to 0, address, writeData and wbData to 32'h0, and wbDestReg to 5'h0.
REQ-023 Reset during ISSUE SHALL abandon the request without a writeback; any later cacheAck SHALL be ignored.
REQ-024 lsuReady SHALL be 1 in the first cycle after reset_n deasserts.

Configuration
REQ-025 With LSU_TIMEOUT_EN defined, a counter SHALL clear on entry to ISSUE and increment each ISSUE cycle without cacheAck. When it reaches TIMEOUT_CYCLES, the unit SHALL go to RESP with wbFault=1 and wbData=FAULT_DATA. cacheAck in that same cycle SHALL win (normal completion).
REQ-026 Without LSU_TIMEOUT_EN, the unit SHALL wait in ISSUE indefinitely, and no counter logic SHALL be synthesized.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2), the operation-class enum and the FAULT_DATA default.
REQ-028 Timeout logic SHALL be one sub-module, lsu_timeout_counter, instantiated only under LSU_TIMEOUT_EN.

Verification
REQ-029 Load, exAddress=32'h0000_1008, cacheAck after 2 ISSUE cycles with readData=32'h0202_0202 -> wbValid for one cycle, wbData=32'h0202_0202, wbRegWrite=1, wbFault=0.
REQ-030 Store, exAddress=32'h0000_1010, exWriteData=32'hC0DE_BABE, immediate ack -> memWrite=1 with address and writeData held during ISSUE, wbRegWrite=0.
REQ-031 Load at 32'h0000_1002 -> cacheReq never asserts; wbFault=1 and wbData=32'hDEAD_BEEF one cycle after accept.
REQ-032 LSU_TIMEOUT_EN defined, load with no ack -> cacheReq high for exactly 8 cycles, then wbFault=1; a late ack is ignored.
REQ-033 reset_n pulsed low in the 2nd ISSUE cycle -> all outputs 0 asynchronously, no wbValid, lsuReady=1 after release.
REQ-034 Bypass, exAddress=32'h0000_00FF, exMemToReg=0 -> no cacheReq; wbData=32'h0000_00FF, wbRegWrite=0, wbValid one cycle after accept.
